acia_rx_ctrl: RTL and testbench

ACIA_RX_CTRL -- requirements
Module: acia_rx_ctrl

---
 rtl/acia_rx_ctrl.sv | 148 ++++++++++++++
 tb/tb_acia_rx_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/acia_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : acia_rx_ctrl
//  Brief    : ACIA receive side: 9-bit {err,data} FIFO, status/control regs,
//             interrupt, optional rts_n hysteresis (enable with ACIA_RX_RTS_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module acia_rx_ctrl #(
  parameter int DEPTH_LOG2 = 3,
  parameter int RTS_HI     = 6,
  parameter int RTS_LO     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_dat,
  input  logic       rx_stb,
  input  logic       rx_err,
  input  logic       cs,
  input  logic       we,
  input  logic       rs,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq,
  output logic       rts_n
);

  localparam int               c_depth = 1 << DEPTH_LOG2;
  localparam int               c_cw    = DEPTH_LOG2 + 1;
  localparam logic [c_cw-1:0]  c_full  = c_cw'(c_depth);

  logic [8:0]            r_mem [0:c_depth-1];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [c_cw-1:0]       r_count;
  logic                  r_overrun;
  logic                  r_rx_ie;
  logic                  r_err_ie;
  logic                  r_err_q;

  logic                  w_err_rise;
  logic                  w_push;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_rd_data;
  logic                  w_rd_stat;
  logic                  w_wr_ctl;
  logic                  w_flush;
  logic                  w_pop;
  logic                  w_push_ok;
  logic [c_cw-1:0]       w_count_nxt;
  logic [8:0]            w_head;
  logic                  w_head_err;
  logic [7:0]            w_status;
  logic                  w_unused_din;

  assign w_err_rise = rx_err & ~r_err_q;
  assign w_push     = rx_stb | w_err_rise;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_full);
  assign w_rd_data  = cs & ~we & rs;
  assign w_rd_stat  = cs & ~we & ~rs;
  assign w_wr_ctl   = cs & we & ~rs;
  assign w_flush    = w_wr_ctl & din[2];
  assign w_pop      = w_rd_data & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push_ok  = w_push & (~w_full | w_pop);
  assign w_unused_din = ^din[7:3];

  always_comb begin
    w_count_nxt = r_count;
    if (w_flush) begin
      w_count_nxt = '0;
    end else if (w_push_ok && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push_ok && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push_ok && !w_flush) begin
      r_mem[r_wr_ptr] <= {w_err_rise, rx_dat};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
      r_rx_ie   <= 1'b0;
      r_err_ie  <= 1'b0;
      r_err_q   <= 1'b0;
    end else begin
      r_err_q <= rx_err;
      r_count <= w_count_nxt;
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_flush) begin
        r_overrun <= 1'b0;
      end else if (w_push && !w_push_ok) begin
        r_overrun <= 1'b1;
      end else if (w_rd_stat) begin
        r_overrun <= 1'b0;
      end
      if (w_wr_ctl) begin
        r_rx_ie  <= din[0];
        r_err_ie <= din[1];
      end
    end
  end

`ifdef ACIA_RX_RTS_EN
  localparam logic [c_cw-1:0] c_rts_hi = c_cw'(RTS_HI);
  localparam logic [c_cw-1:0] c_rts_lo = c_cw'(RTS_LO);
  logic r_rts_n;

  // Hysteresis: judged on the post-update count, held between thresholds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rts_n <= 1'b0;
    end else if (w_count_nxt >= c_rts_hi) begin
      r_rts_n <= 1'b1;
    end else if (w_count_nxt <= c_rts_lo) begin
      r_rts_n <= 1'b0;
    end
  end
  assign rts_n = r_rts_n;
`else
  logic w_unused_rts;
  assign w_unused_rts = (RTS_HI > RTS_LO);
  assign rts_n = 1'b0;
`endif

  assign w_head     = r_mem[r_rd_ptr];
  assign w_head_err = ~w_empty & w_head[8];
  assign irq        = (r_rx_ie & ~w_empty) | (r_err_ie & (r_overrun | w_head_err));
  assign w_status   = {irq, 2'b00, rts_n, w_full, r_overrun, w_head_err, ~w_empty};
  assign dout       = rs ? (w_empty ? 8'h00 : w_head[7:0]) : w_status;

endmodule
`default_nettype wire

// File: tb/tb_acia_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acia_rx_ctrl
//  Brief    : Directed scoreboard bench for acia_rx_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_acia_rx_ctrl;

`ifdef ACIA_RX_RTS_EN
  localparam bit c_rts = 1'b1;
`else
  localparam bit c_rts = 1'b0;
`endif
  localparam logic [7:0] c_rb = c_rts ? 8'h10 : 8'h00;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_dat;
  logic       rx_stb;
  logic       rx_err;
  logic       cs;
  logic       we;
  logic       rs;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq;
  logic       rts_n;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  acia_rx_ctrl dut (
    .clk(clk), .rst(rst), .rx_dat(rx_dat), .rx_stb(rx_stb), .rx_err(rx_err),
    .cs(cs), .we(we), .rs(rs), .din(din), .dout(dout), .irq(irq), .rts_n(rts_n)
  );

  always #5 clk = ~clk;

  // Every bus read cycle consumes one expected dout value.
  always @(negedge clk) begin
    if (cs && !we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected got %02h exp none", dout);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          errors++;
          $display("FAIL read_%s got %02h exp %02h", rs ? "data" : "stat", dout, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0b exp %0b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    rx_dat = b; rx_stb = 1'b1;
    tick();
    rx_stb = 1'b0;
  endtask

  task automatic push_err(input logic [7:0] b);
    rx_dat = b; rx_err = 1'b1;
    tick();
    rx_err = 1'b0;
  endtask

  task automatic rd(input logic rsel, input logic [7:0] e);
    exp_q.push_back(e);
    cs = 1'b1; we = 1'b0; rs = rsel;
    tick();
    cs = 1'b0;
  endtask

  task automatic wr_ctl(input logic [7:0] d);
    cs = 1'b1; we = 1'b1; rs = 1'b0; din = d;
    tick();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic push_pop(input logic [7:0] b, input logic [7:0] e);
    exp_q.push_back(e);
    rx_dat = b; rx_stb = 1'b1; cs = 1'b1; we = 1'b0; rs = 1'b1;
    tick();
    rx_stb = 1'b0; cs = 1'b0;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_dat = 8'h00; rx_stb = 1'b0; rx_err = 1'b0;
    cs = 1'b0; we = 1'b0; rs = 1'b0; din = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_irq", irq, 1'b0);
    chk("reset_rts", rts_n, 1'b0);
    rd(1'b0, 8'h00);

    // Two bytes in, read back in order.
    push(8'hA5); push(8'h3C);
    rd(1'b0, 8'h01);
    rd(1'b1, 8'hA5);
    rd(1'b1, 8'h3C);
    rd(1'b0, 8'h00);

    // Overrun on the ninth byte; first status read reports then clears it.
    for (int i = 0; i < 9; i++) push(8'h10 + 8'(i));
    chk("full_rts", rts_n, c_rts);
    rd(1'b0, 8'h0D | c_rb);
    rd(1'b0, 8'h09 | c_rb);
    for (int i = 0; i < 8; i++) rd(1'b1, 8'h10 + 8'(i));
    rd(1'b0, 8'h00);
    rd(1'b1, 8'h00);

    // Push and pop together while full: no overrun, new byte lands last.
    for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
    push_pop(8'h28, 8'h20);
    rd(1'b0, 8'h09 | c_rb);
    for (int i = 1; i < 9; i++) rd(1'b1, 8'h20 + 8'(i));
    rd(1'b0, 8'h00);

    // Push and pop together while empty: pop ignored, push kept.
    push_pop(8'h29, 8'h00);
    rd(1'b0, 8'h01);
    rd(1'b1, 8'h29);

    // Framing-error entry raises irq through err_ie.
    wr_ctl(8'h02);
    push_err(8'h55);
    chk("err_irq", irq, 1'b1);
    rd(1'b0, 8'h83);
    rd(1'b1, 8'h55);
    chk("err_irq_clr", irq, 1'b0);
    rd(1'b0, 8'h00);

    // rx_ie tracks not-empty.
    wr_ctl(8'h01);
    chk("rxie_empty", irq, 1'b0);
    push(8'h66);
    chk("rxie_data", irq, 1'b1);
    rd(1'b1, 8'h66);
    chk("rxie_drained", irq, 1'b0);
    wr_ctl(8'h00);

    // rts_n hysteresis between 6 and 2 entries.
    for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
    chk("rts_at5", rts_n, 1'b0);
    push(8'h35);
    chk("rts_at6", rts_n, c_rts);
    for (int i = 0; i < 3; i++) rd(1'b1, 8'h30 + 8'(i));
    chk("rts_at3", rts_n, c_rts);
    rd(1'b1, 8'h33);
    chk("rts_at2", rts_n, 1'b0);
    rd(1'b1, 8'h34);
    rd(1'b1, 8'h35);

    // Flush with five entries, then flush racing a push.
    for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
    wr_ctl(8'h04);
    rd(1'b0, 8'h00);
    push(8'h45); push(8'h46);
    rx_dat = 8'h47; rx_stb = 1'b1;
    wr_ctl(8'h04);
    rx_stb = 1'b0;
    rd(1'b0, 8'h00);

    // Reset mid-stream beats a concurrent push and clears everything.
    wr_ctl(8'h03);
    for (int i = 0; i < 9; i++) push(8'h50 + 8'(i));
    chk("pre_rst_irq", irq, 1'b1);
    rst = 1'b1; rx_dat = 8'h99; rx_stb = 1'b1;
    tick();
    rst = 1'b0; rx_stb = 1'b0;
    chk("rst_irq", irq, 1'b0);
    chk("rst_rts", rts_n, 1'b0);
    rd(1'b0, 8'h00);
    rd(1'b1, 8'h00);
    push(8'h77);
    chk("rst_ie_cleared", irq, 1'b0);
    rd(1'b0, 8'h01);
    rd(1'b1, 8'h77);

    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
